serial_pattern_tx: RTL
======================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the maximum pattern length in bits.
REQ-002 SHALL have parameter LW, default 4, the LEN field width; WIDTH SHALL equal 2**LW.
REQ-003 SHALL have port CP, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port START, input, 1, transmit request, accepted only when READY=1.
REQ-006 SHALL have port STOP, input, 1, abort request.
REQ-007 SHALL have port PATTERN, input, WIDTH, the bits to send, sampled on accept.
REQ-008 SHALL have port LEN, input, LW, pattern length minus 1, sampled on accept.
REQ-009 SHALL have port REPS, input, 4, repetition count minus 1, sampled on accept.
REQ-010 SHALL have port D, output, 1, registered serial data, matching the D input of the team's sequence detectors.
REQ-011 SHALL have port READY, output, 1, high when idle and able to accept START.
REQ-012 SHALL have port BUSY, output, 1, high while bits are being driven.
REQ-013 SHALL have port FRAME, output, 1, high during the first bit of each repetition.
REQ-014 SHALL have port DONE, output, 1, one-cycle pulse on normal completion.

Function
REQ-015 SHALL implement two states: IDLE (READY=1, BUSY=0, D=0) and SEND (READY=0, BUSY=1).
REQ-016 SHALL, in IDLE with START=1 and STOP=0, latch PATTERN, LEN and REPS, enter SEND, and drive D=PATTERN[LEN] with FRAME=1 from that same edge; first bit has zero-cycle latency after the accepting edge.
REQ-017 SHALL send bits MSB-first from PATTERN[LEN] down to PATTERN[0], one bit per CP cycle; bits above LEN are ignored.
REQ-018 SHALL restart at PATTERN[LEN] after bit 0, with FRAME=1 on that bit, until LEN+1 bits have been sent REPS+1 times; there is no gap between repetitions.
REQ-019 SHALL hold BUSY=1 for exactly (LEN+1)*(REPS+1) cycles per transmission.
REQ-020 SHALL, on the edge after the final bit, set D=0, FRAME=0, BUSY=0, READY=1, DONE=1 for one cycle, and return to IDLE.
REQ-021 SHALL accept a START present in the cycle DONE is high, because READY is already 1, giving back-to-back transmissions separated by exactly one D=0 idle cycle.
REQ-022 SHALL ignore START while in SEND; the latched pattern and counters do not change mid-transmission.
REQ-023 SHALL, when STOP=1 in SEND, return to IDLE on the next edge with D=0, FRAME=0 and DONE=0.
REQ-024 SHALL give STOP priority over START in all states: STOP=1 with START=1 in IDLE is not accepted.
REQ-025 SHALL handle LEN=0 (1-bit pattern) and REPS=0 (single repetition) with no special-case timing.
REQ-026 SHALL use bit and repetition counters that never wrap: maximum values are LEN=15 and REPS=15 (256 bits).

Reset
REQ-027 SHALL, when RST=1 at a rising CP edge, set IDLE, D=0, READY=1, BUSY=0, FRAME=0, DONE=0, and clear both counters.
REQ-028 SHALL give RST priority over START and STOP; RST mid-transmission aborts with no DONE pulse.
REQ-029 SHALL leave the latched pattern registers don't-care after reset.

Verification
REQ-030 Scenario: PATTERN=16'h000D, LEN=3, REPS=0, one START pulse -> D=1,1,0,1 on 4 consecutive cycles, BUSY 4 cycles, then DONE=1 for 1 cycle with D=0.
REQ-031 Scenario: PATTERN=16'h0006, LEN=2, REPS=3 -> D=110110110110 over 12 cycles, FRAME high on bits 1, 4, 7 and 10, then one DONE pulse.
REQ-032 Scenario: PATTERN=16'hA5C3, LEN=15, REPS=0 -> D=1010010111000011 over 16 cycles, then DONE.
REQ-033 Scenario: PATTERN=16'h000E, LEN=3, REPS=3, STOP during the 3rd bit -> next edge D=0, READY=1, BUSY=0, DONE never asserted.
REQ-034 Scenario: START held high, PATTERN=1, LEN=0, REPS=0 -> D alternates 1,0,1,0 and DONE pulses on every 0 cycle.
REQ-035 Scenario: RST asserted during the 5th bit of the REQ-031 stimulus -> all outputs at reset values after that edge, no DONE; a following START transmits correctly.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN[LEN:0] out MSB-first on D,
// repeated REPS+1 times back to back, with FRAME marking each repetition start.
module serial_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int LW    = 4
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [LW-1:0]    LEN,
  input  logic [3:0]       REPS,
  output logic             D,
  output logic             READY,
  output logic             BUSY,
  output logic             FRAME,
  output logic             DONE
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    bit_q, bit_d;
  logic [3:0]       rep_q, rep_d;
  logic             d_q, d_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;

  logic accept, last_bit, last_rep;

  assign accept   = START && !STOP;
  assign last_bit = (bit_q == '0);
  assign last_rep = (rep_q == 4'd0);

  // State and counter register
  always_ff @(posedge CP) begin
    if (RST) begin
      state_q <= IDLE;
      bit_q   <= '0;
      rep_q   <= '0;
      d_q     <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      d_q     <= d_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // Latched request fields carry no reset; they are only read in SEND.
  always_ff @(posedge CP) begin
    pat_q <= pat_d;
    len_q <= len_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (STOP || (last_bit && last_rep)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    d_d     = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pat_d   = PATTERN;
          len_d   = LEN;
          bit_d   = LEN;
          rep_d   = REPS;
          d_d     = PATTERN[LEN];
          frame_d = 1'b1;
        end
      end
      SEND: begin
        if (STOP) begin
          bit_d = '0;
          rep_d = 4'd0;
        end else if (last_bit && last_rep) begin
          done_d = 1'b1;
        end else if (last_bit) begin
          // Wrap to the top bit for the next repetition, no idle gap.
          bit_d   = len_q;
          rep_d   = rep_q - 4'd1;
          d_d     = pat_q[len_q];
          frame_d = 1'b1;
        end else begin
          bit_d = bit_q - 1'b1;
          d_d   = pat_q[bit_q - 1'b1];
        end
      end
      default: ;
    endcase
  end

  assign D     = d_q;
  assign FRAME = frame_q;
  assign DONE  = done_q;
  assign READY = (state_q == IDLE);
  assign BUSY  = (state_q == SEND);

endmodule
